// File: rtl/ssio_ddr_in_align.sv
// ---------------------------------------------------------------------------
// ssio_ddr_in_align
//
// Source-synchronous DDR receive path with half-cycle word alignment.
// WIDTH lanes are captured by a DDR input register (iddr, below). Each
// rising/falling sample pair is assembled into a 2*WIDTH-bit word. A small
// FSM searches a training pattern to decide whether words start on the
// rising edge (normal) or on the preceding falling edge (swapped), and then
// monitors the pattern while locked.
//
// Ports
//   clk          in   1      DDR clock; drives the capture registers and all logic
//   rst          in   1      asynchronous, active-high reset
//   input_d      in   WIDTH  DDR data pins
//   train_en     in   1      input_d currently carries TRAIN_PATTERN
//   relock       in   1      single-cycle pulse: restart the search
//   output_q1    out  WIDTH  aligned rising-half sample
//   output_q2    out  WIDTH  aligned falling-half sample
//   output_valid out  1      output word was produced while locked
//   locked       out  1      alignment FSM is in LOCKED
//   swapped      out  1      0 = normal alignment, 1 = half-cycle shifted
//   lock_lost    out  1      single-cycle pulse when misses drop the lock
// ---------------------------------------------------------------------------

// DDR input register. Rising sample is taken on posedge and the following
// falling sample on negedge; both are re-timed onto the next rising edge so
// q1/q2 always present one matched {rise, fall} pair per clock.
module iddr #(
    parameter string TARGET      = "GENERIC",
    parameter string IODDR_STYLE = "IODDR2",
    parameter int    WIDTH       = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q1,
    output logic [WIDTH-1:0] q2
);

    localparam bit KNOWN_TARGET = (TARGET == "SIM") || (TARGET == "GENERIC") ||
                                  (TARGET == "XILINX") || (TARGET == "ALTERA");
    localparam bit KNOWN_STYLE  = (IODDR_STYLE == "IODDR") || (IODDR_STYLE == "IODDR2");

    if (KNOWN_TARGET && KNOWN_STYLE) begin : g_capture
        logic [WIDTH-1:0] d_rise;
        logic [WIDTH-1:0] d_fall;
        logic [WIDTH-1:0] q_rise;
        logic [WIDTH-1:0] q_fall;

        // Rising-edge capture plus the re-timing stage for both halves.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                d_rise <= '0;
                q_rise <= '0;
                q_fall <= '0;
            end else begin
                d_rise <= d;
                q_rise <= d_rise;
                q_fall <= d_fall;
            end
        end

        // Falling-edge capture of the second half of the bit period.
        always_ff @(negedge clk or posedge rst) begin
            if (rst) begin
                d_fall <= '0;
            end else begin
                d_fall <= d;
            end
        end

        assign q1 = q_rise;
        assign q2 = q_fall;
    end else begin : g_unsupported
        // An unrecognised target/style produces no data rather than guessing.
        assign q1 = '0;
        assign q2 = '0;
    end

endmodule

module ssio_ddr_in_align #(
    parameter string               TARGET        = "GENERIC",
    parameter string               IODDR_STYLE   = "IODDR2",
    parameter int                  WIDTH         = 4,
    parameter int                  PIPELINE      = 1,
    parameter logic [2*WIDTH-1:0]  TRAIN_PATTERN = 8'h5A,
    parameter int                  LOCK_COUNT    = 16,
    parameter int                  UNLOCK_COUNT  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] input_d,
    input  logic             train_en,
    input  logic             relock,
    output logic [WIDTH-1:0] output_q1,
    output logic [WIDTH-1:0] output_q2,
    output logic             output_valid,
    output logic             locked,
    output logic             swapped,
    output logic             lock_lost
);

    localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
    localparam int MISS_W  = $clog2(UNLOCK_COUNT + 1);
    localparam logic [MATCH_W-1:0] MATCH_MAX = MATCH_W'(LOCK_COUNT);
    localparam logic [MISS_W-1:0]  MISS_MAX  = MISS_W'(UNLOCK_COUNT);

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t             state, state_next;
    logic [WIDTH-1:0]   r1, r2, r2_prev;
    logic [MATCH_W-1:0] match_cnt, match_cnt_next;
    logic [MISS_W-1:0]  miss_cnt, miss_cnt_next;
    logic               cand_prev, cand_prev_next;
    logic               swapped_reg, swapped_next;
    logic               lock_lost_reg, lock_lost_next;
    logic               match_normal, match_shift, candidate, chosen_match;
    logic [2*WIDTH-1:0] word_sel;

    logic [2*WIDTH-1:0] pipe_word [0:PIPELINE];
    logic [PIPELINE:0]  pipe_valid;

    iddr #(
        .TARGET      (TARGET),
        .IODDR_STYLE (IODDR_STYLE),
        .WIDTH       (WIDTH)
    ) u_iddr (
        .clk (clk),
        .rst (rst),
        .d   (input_d),
        .q1  (r1),
        .q2  (r2)
    );

    // Previous falling sample, needed to build the half-cycle shifted word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r2_prev <= '0;
        end else begin
            r2_prev <= r2;
        end
    end

    // Alignment FSM state and counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= SEARCH;
            match_cnt     <= '0;
            miss_cnt      <= '0;
            cand_prev     <= 1'b0;
            swapped_reg   <= 1'b0;
            lock_lost_reg <= 1'b0;
        end else begin
            state         <= state_next;
            match_cnt     <= match_cnt_next;
            miss_cnt      <= miss_cnt_next;
            cand_prev     <= cand_prev_next;
            swapped_reg   <= swapped_next;
            lock_lost_reg <= lock_lost_next;
        end
    end

    // Next-state logic. The normal phase is preferred when both phases match,
    // so a stream that happens to match both ways never locks shifted.
    // The lock decision looks at the updated match count, so the edge that
    // registers the final required match is the edge that enters LOCKED.
    always_comb begin
        match_normal   = ({r1, r2} == TRAIN_PATTERN);
        match_shift    = ({r2_prev, r1} == TRAIN_PATTERN);
        candidate      = ~match_normal;
        chosen_match   = swapped_reg ? match_shift : match_normal;

        state_next     = state;
        match_cnt_next = match_cnt;
        miss_cnt_next  = miss_cnt;
        cand_prev_next = cand_prev;
        swapped_next   = swapped_reg;
        lock_lost_next = 1'b0;

        if (relock) begin
            state_next     = SEARCH;
            match_cnt_next = '0;
            miss_cnt_next  = '0;
            cand_prev_next = 1'b0;
        end else begin
            case (state)
                SEARCH: begin
                    if (train_en) begin
                        if (match_normal || match_shift) begin
                            cand_prev_next = candidate;
                            if (candidate == cand_prev) begin
                                if (match_cnt != MATCH_MAX) begin
                                    match_cnt_next = match_cnt + MATCH_W'(1);
                                end
                            end else begin
                                match_cnt_next = MATCH_W'(1);
                            end
                        end else begin
                            match_cnt_next = '0;
                        end

                        if (match_cnt_next == MATCH_MAX) begin
                            state_next     = LOCKED;
                            swapped_next   = candidate;
                            miss_cnt_next  = '0;
                            match_cnt_next = '0;
                        end
                    end
                end

                LOCKED: begin
                    if (train_en) begin
                        if (chosen_match) begin
                            miss_cnt_next = '0;
                        end else if (miss_cnt != MISS_MAX) begin
                            miss_cnt_next = miss_cnt + MISS_W'(1);
                        end

                        if (miss_cnt_next == MISS_MAX) begin
                            state_next     = SEARCH;
                            match_cnt_next = '0;
                            miss_cnt_next  = '0;
                            lock_lost_next = 1'b1;
                        end
                    end
                end

                default: begin
                    state_next = SEARCH;
                end
            endcase
        end
    end

    assign word_sel = swapped_reg ? {r2_prev, r1} : {r1, r2};

    // Output pipeline. Valid travels with the word so the first valid word
    // is the first one assembled with the freshly chosen alignment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i <= PIPELINE; i++) begin
                pipe_word[i] <= '0;
            end
            pipe_valid <= '0;
        end else begin
            pipe_word[0]  <= word_sel;
            pipe_valid[0] <= (state == LOCKED);
            for (int i = 1; i <= PIPELINE; i++) begin
                pipe_word[i]  <= pipe_word[i-1];
                pipe_valid[i] <= pipe_valid[i-1];
            end
        end
    end

    assign output_q1    = pipe_word[PIPELINE][2*WIDTH-1:WIDTH];
    assign output_q2    = pipe_word[PIPELINE][WIDTH-1:0];
    assign output_valid = pipe_valid[PIPELINE];
    assign locked       = (state == LOCKED);
    assign swapped      = swapped_reg;
    assign lock_lost    = lock_lost_reg;

endmodule

// File: tb/tb_ssio_ddr_in_align.sv
// ---------------------------------------------------------------------------
// tb_ssio_ddr_in_align
//
// Drives DDR pairs into ssio_ddr_in_align and keeps a behavioural model of
// the alignment rules. Each modelled clock pushes the expected status into
// one queue and, when a word is produced under lock, the expected word into
// another; an independent monitor pops and compares on the falling edge.
// ---------------------------------------------------------------------------
module tb_ssio_ddr_in_align;

    localparam int         WIDTH         = 4;
    localparam int         PIPELINE      = 1;
    localparam int         LOCK_COUNT    = 16;
    localparam int         UNLOCK_COUNT  = 4;
    localparam logic [7:0] TRAIN_PATTERN = 8'h5A;
    // The DUT evaluates a pair two rising edges after its rise half is driven.
    localparam int         CAPTURE_LAG   = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [WIDTH-1:0] input_d = '0;
    logic             train_en = 1'b0;
    logic             relock = 1'b0;
    logic [WIDTH-1:0] output_q1, output_q2;
    logic             output_valid, locked, swapped, lock_lost;

    typedef struct {
        bit locked;
        bit swapped;
        bit lost;
        bit valid;
    } status_t;

    status_t          status_q[$];
    logic [7:0]       data_q[$];
    bit               lock_hist[$];

    logic [3:0]       rise_l[$];
    logic [3:0]       fall_l[$];
    bit               ten_l[$];
    bit               rel_l[$];

    // Model of the alignment rules.
    bit               m_locked, m_swapped, m_cand;
    int               m_match, m_miss;
    logic [3:0]       m_prev_fall;

    int               checks = 0;
    int               failures = 0;

    status_t          mon_s;
    logic [7:0]       mon_w;

    ssio_ddr_in_align #(
        .TARGET        ("GENERIC"),
        .IODDR_STYLE   ("IODDR2"),
        .WIDTH         (WIDTH),
        .PIPELINE      (PIPELINE),
        .TRAIN_PATTERN (TRAIN_PATTERN),
        .LOCK_COUNT    (LOCK_COUNT),
        .UNLOCK_COUNT  (UNLOCK_COUNT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .input_d      (input_d),
        .train_en     (train_en),
        .relock       (relock),
        .output_q1    (output_q1),
        .output_q2    (output_q2),
        .output_valid (output_valid),
        .locked       (locked),
        .swapped      (swapped),
        .lock_lost    (lock_lost)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic addPairs(input logic [3:0] rise, input logic [3:0] fall,
                            input bit ten, input bit rel, input int count);
        for (int i = 0; i < count; i++) begin
            rise_l.push_back(rise);
            fall_l.push_back(fall);
            ten_l.push_back(ten);
            rel_l.push_back(rel);
        end
    endtask

    task automatic addRandomPairs(input bit ten, input int count);
        for (int i = 0; i < count; i++) begin
            rise_l.push_back(4'($urandom_range(0, 15)));
            fall_l.push_back(4'($urandom_range(0, 15)));
            ten_l.push_back(ten);
            rel_l.push_back(1'b0);
        end
    endtask

    // One rising edge of the reference: the word the DUT assembles from the
    // pair it sees, plus the lock/unlock rules applied to that pair.
    task automatic modelStep(input logic [3:0] r1, input logic [3:0] r2,
                             input bit ten, input bit rel);
        logic [7:0] w_norm, w_shift;
        bit         mn, ms, cand, hit;
        status_t    st;
        w_norm  = {r1, r2};
        w_shift = {m_prev_fall, r1};
        mn      = (w_norm == TRAIN_PATTERN);
        ms      = (w_shift == TRAIN_PATTERN);
        if (m_locked) data_q.push_back(m_swapped ? w_shift : w_norm);
        lock_hist.push_back(m_locked);
        st.lost = 1'b0;
        if (rel) begin
            m_locked = 1'b0;
            m_match  = 0;
            m_miss   = 0;
        end else if (!m_locked) begin
            if (ten) begin
                if (mn || ms) begin
                    cand    = !mn;
                    m_match = (m_match > 0 && cand == m_cand) ? m_match + 1 : 1;
                    if (m_match > LOCK_COUNT) m_match = LOCK_COUNT;
                    m_cand  = cand;
                end else begin
                    m_match = 0;
                end
                if (m_match == LOCK_COUNT) begin
                    m_locked  = 1'b1;
                    m_swapped = m_cand;
                    m_miss    = 0;
                    m_match   = 0;
                end
            end
        end else if (ten) begin
            hit    = m_swapped ? ms : mn;
            m_miss = hit ? 0 : m_miss + 1;
            if (m_miss >= UNLOCK_COUNT) begin
                m_locked = 1'b0;
                m_match  = 0;
                m_miss   = 0;
                st.lost  = 1'b1;
            end
        end
        m_prev_fall = r2;
        st.locked   = m_locked;
        st.swapped  = m_swapped;
        st.valid    = (lock_hist.size() > PIPELINE) ? lock_hist[lock_hist.size() - 1 - PIPELINE] : 1'b0;
        status_q.push_back(st);
    endtask

    // Plays the queued pairs onto the pins and steps the model in lockstep.
    // Two extra zero pairs flush the capture stages.
    task automatic applyStimulus();
        int n;
        n = rise_l.size();
        for (int t = 0; t < n + CAPTURE_LAG; t++) begin
            @(negedge clk);
            #2;
            input_d = (t < n) ? rise_l[t] : 4'h0;
            if (t >= CAPTURE_LAG) begin
                train_en = ten_l[t - CAPTURE_LAG];
                relock   = rel_l[t - CAPTURE_LAG];
                modelStep(rise_l[t - CAPTURE_LAG], fall_l[t - CAPTURE_LAG],
                          ten_l[t - CAPTURE_LAG], rel_l[t - CAPTURE_LAG]);
            end else begin
                train_en = 1'b0;
                relock   = 1'b0;
                modelStep(4'h0, 4'h0, 1'b0, 1'b0);
            end
            @(posedge clk);
            #2;
            input_d = (t < n) ? fall_l[t] : 4'h0;
        end
        train_en = 1'b0;
        relock   = 1'b0;
        rise_l.delete();
        fall_l.delete();
        ten_l.delete();
        rel_l.delete();
    endtask

    task automatic doReset();
        rst      = 1'b1;
        train_en = 1'b0;
        relock   = 1'b0;
        input_d  = '0;
        status_q.delete();
        data_q.delete();
        lock_hist.delete();
        m_locked    = 1'b0;
        m_swapped   = 1'b0;
        m_cand      = 1'b0;
        m_match     = 0;
        m_miss      = 0;
        m_prev_fall = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1 rst = 1'b0;
    endtask

    // Monitor: compares status every cycle and pops a word whenever the DUT
    // flags one as valid.
    always @(negedge clk) begin
        if (!rst) begin
            if (status_q.size() != 0) begin
                mon_s = status_q.pop_front();
                checkOutput("locked", 32'(locked), 32'(mon_s.locked));
                checkOutput("swapped", 32'(swapped), 32'(mon_s.swapped));
                checkOutput("lock_lost", 32'(lock_lost), 32'(mon_s.lost));
                checkOutput("output_valid", 32'(output_valid), 32'(mon_s.valid));
            end
            if (output_valid) begin
                if (data_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_word actual=%0h expected=none at %0t",
                             {output_q1, output_q2}, $time);
                end else begin
                    mon_w = data_q.pop_front();
                    checkOutput("word", 32'({output_q1, output_q2}), 32'(mon_w));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL timeout actual=running expected=finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin
        doReset();

        // Reset values before any traffic.
        @(negedge clk);
        checkOutput("reset_locked", 32'(locked), 32'd0);
        checkOutput("reset_valid", 32'(output_valid), 32'd0);
        checkOutput("reset_q", 32'({output_q1, output_q2}), 32'd0);

        // Normal-phase training, free-running data, then the miss bursts.
        addPairs(4'h5, 4'hA, 1'b1, 1'b0, 20);
        addRandomPairs(1'b0, 12);
        addPairs(4'hF, 4'hF, 1'b1, 1'b0, 3);
        addPairs(4'h5, 4'hA, 1'b1, 1'b0, 1);
        addPairs(4'hF, 4'hF, 1'b1, 1'b0, 4);
        addPairs(4'h5, 4'hA, 1'b1, 1'b0, 6);
        applyStimulus();

        // Half-cycle shifted stream locks swapped.
        doReset();
        addPairs(4'hA, 4'h5, 1'b1, 1'b0, 22);
        addRandomPairs(1'b0, 12);
        applyStimulus();

        // Relock on the 16th match, then a held count across train_en=0.
        doReset();
        addPairs(4'h5, 4'hA, 1'b1, 1'b0, 15);
        addPairs(4'h5, 4'hA, 1'b1, 1'b1, 1);
        addPairs(4'h5, 4'hA, 1'b1, 1'b0, 8);
        addRandomPairs(1'b0, 5);
        addPairs(4'h5, 4'hA, 1'b1, 1'b0, 10);
        applyStimulus();

        // Reset while locked clears outputs immediately.
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        checkOutput("midreset_locked", 32'(locked), 32'd0);
        checkOutput("midreset_valid", 32'(output_valid), 32'd0);
        checkOutput("midreset_swapped", 32'(swapped), 32'd0);
        checkOutput("midreset_lost", 32'(lock_lost), 32'd0);
        checkOutput("midreset_q", 32'({output_q1, output_q2}), 32'd0);
        doReset();
        addPairs(4'h5, 4'hA, 1'b1, 1'b0, 18);
        applyStimulus();

        // Randomised blocks of good, shifted and noisy traffic.
        for (int b = 0; b < 14; b++) begin
            int kind, len;
            bit ten;
            kind = $urandom_range(0, 3);
            len  = $urandom_range(8, 40);
            ten  = ($urandom_range(0, 4) != 0);
            for (int i = 0; i < len; i++) begin
                bit rel;
                rel = ($urandom_range(0, 59) == 0);
                case (kind)
                    0: addPairs(4'h5, 4'hA, ten, rel, 1);
                    1: addPairs(4'hA, 4'h5, ten, rel, 1);
                    2: begin
                        addRandomPairs(ten, 1);
                        rel_l[rel_l.size() - 1] = rel;
                    end
                    default: begin
                        if ($urandom_range(0, 5) == 0) begin
                            addRandomPairs(ten, 1);
                        end else begin
                            addPairs(4'h5, 4'hA, ten, rel, 1);
                        end
                    end
                endcase
            end
        end
        applyStimulus();

        addPairs(4'h0, 4'h0, 1'b0, 1'b0, 6);
        applyStimulus();
        @(negedge clk);
        #1;
        checkOutput("status_drained", 32'(status_q.size()), 32'd0);
        checkOutput("words_in_flight_ok", 32'(data_q.size() <= PIPELINE + 1), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
